decode_issue_stage: RTL and testbench

RV32I decode/issue pipeline stage. Takes fetched instruction words over a valid/ready handshake and decodes them. It drives the register-file read addresses and registers the ALU operand/control bundle (op1, op2, funct3 operation, arith/logic select) toward execute. A busy-register scoreboard stalls issue on RAW hazards until writeback clears the destination.

---
 rtl/decode_issue_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_issue_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes fetched words into a registered ALU bundle
// and holds issue back on RAW hazards tracked by a busy-register scoreboard.
module decode_issue_stage #(
  parameter int unsigned NB_WORD     = 32,
  parameter int unsigned NB_FUNCT3   = 3,
  parameter int unsigned NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NB_WORD-1:0]     i_instr,
  input  logic [NB_WORD-1:0]     i_pc,
  output logic [NB_REG_ADDR-1:0] o_rs1_addr,
  output logic [NB_REG_ADDR-1:0] o_rs2_addr,
  input  logic [NB_WORD-1:0]     i_rs1_data,
  input  logic [NB_WORD-1:0]     i_rs2_data,
  input  logic                   i_wb_valid,
  input  logic [NB_REG_ADDR-1:0] i_wb_rd,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NB_WORD-1:0]     o_op1,
  output logic [NB_WORD-1:0]     o_op2,
  output logic [NB_FUNCT3-1:0]   o_operation,
  output logic                   o_arith_logic,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic                   o_rd_we,
  output logic                   o_is_load,
  output logic                   o_is_store,
  output logic                   o_is_branch,
  output logic                   o_is_jump,
  output logic [NB_FUNCT3-1:0]   o_funct3_raw,
  output logic [NB_WORD-1:0]     o_store_data,
  output logic [NB_WORD-1:0]     o_imm,
  output logic [NB_WORD-1:0]     o_pc,
  output logic                   o_illegal
);

  localparam int unsigned NB_REGS = 1 << NB_REG_ADDR;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [NB_FUNCT3-1:0] F3_ADD_SUB = NB_FUNCT3'(0);
  localparam logic [NB_FUNCT3-1:0] F3_SRL_SRA = NB_FUNCT3'(5);

  logic [6:0]             w_opcode;
  logic [NB_FUNCT3-1:0]   w_funct3;
  logic [NB_REG_ADDR-1:0] w_rd;
  logic [NB_WORD-1:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [NB_WORD-1:0]     w_op1, w_op2, w_imm;
  logic [NB_FUNCT3-1:0]   w_operation;
  logic                   w_arith_logic, w_we_raw, w_rd_we;
  logic                   w_is_load, w_is_store, w_is_branch, w_is_jump, w_illegal;
  logic                   w_use_rs1, w_use_rs2, w_hazard, w_accept;
  logic [NB_REGS-1:0]     r_busy, w_busy_eff, w_wb_mask, w_set_mask;

  assign w_opcode   = i_instr[6:0];
  assign w_funct3   = i_instr[14:12];
  assign w_rd       = i_instr[11:7];
  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  assign w_imm_i = {{(NB_WORD-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{(NB_WORD-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{(NB_WORD-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};
  assign w_imm_j = {{(NB_WORD-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

  // Opcode decode into ALU operands, class flags and register usage
  always_comb begin
    w_op1         = '0;
    w_op2         = '0;
    w_imm         = '0;
    w_operation   = F3_ADD_SUB;
    w_arith_logic = 1'b0;
    w_we_raw      = 1'b0;
    w_is_load     = 1'b0;
    w_is_store    = 1'b0;
    w_is_branch   = 1'b0;
    w_is_jump     = 1'b0;
    w_illegal     = 1'b0;
    w_use_rs1     = 1'b0;
    w_use_rs2     = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_op1 = i_rs1_data; w_op2 = i_rs2_data; w_operation = w_funct3;
        w_arith_logic = i_instr[30]; w_we_raw = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        w_op1 = i_rs1_data; w_op2 = w_imm_i; w_imm = w_imm_i; w_operation = w_funct3;
        w_arith_logic = (w_funct3 == F3_SRL_SRA) && i_instr[30];
        w_we_raw = 1'b1; w_use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        w_op1 = i_rs1_data; w_op2 = w_imm_i; w_imm = w_imm_i;
        w_we_raw = 1'b1; w_is_load = 1'b1; w_use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_op1 = i_rs1_data; w_op2 = w_imm_s; w_imm = w_imm_s;
        w_is_store = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        w_op2 = w_imm_u; w_imm = w_imm_u; w_we_raw = 1'b1;
      end
      OPC_AUIPC: begin
        w_op1 = i_pc; w_op2 = w_imm_u; w_imm = w_imm_u; w_we_raw = 1'b1;
      end
      OPC_JAL: begin
        w_op1 = i_pc; w_op2 = NB_WORD'(4); w_imm = w_imm_j;
        w_we_raw = 1'b1; w_is_jump = 1'b1;
      end
      OPC_JALR: begin
        w_op1 = i_pc; w_op2 = NB_WORD'(4); w_imm = w_imm_i;
        w_we_raw = 1'b1; w_is_jump = 1'b1; w_use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        w_op1 = i_rs1_data; w_op2 = i_rs2_data; w_imm = w_imm_b; w_arith_logic = 1'b1;
        w_is_branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rd_we = w_we_raw && (w_rd != '0);

  // A writeback in the same cycle releases its register before the hazard test
  assign w_wb_mask  = i_wb_valid ? (NB_REGS'(1) << i_wb_rd) : '0;
  assign w_busy_eff = r_busy & ~w_wb_mask;
  assign w_hazard   = i_valid && ((w_use_rs1 && w_busy_eff[o_rs1_addr]) ||
                                  (w_use_rs2 && w_busy_eff[o_rs2_addr]));
  assign o_ready    = !i_flush && !w_hazard && (!o_valid || i_ready);
  assign w_accept   = i_valid && o_ready;
  assign w_set_mask = (w_accept && w_rd_we) ? (NB_REGS'(1) << w_rd) : '0;

  // Scoreboard: set on issue beats clear on writeback; x0 never busy
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) r_busy <= '0;
    else                    r_busy <= ((r_busy & ~w_wb_mask) | w_set_mask) & ~NB_REGS'(1);
  end

  // Issue bundle register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;       o_op1 <= '0;           o_op2 <= '0;
      o_operation <= '0;     o_arith_logic <= 1'b0; o_rd <= '0;
      o_rd_we <= 1'b0;       o_is_load <= 1'b0;     o_is_store <= 1'b0;
      o_is_branch <= 1'b0;   o_is_jump <= 1'b0;     o_funct3_raw <= '0;
      o_store_data <= '0;    o_imm <= '0;           o_pc <= '0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (w_accept) begin
      o_valid <= 1'b1;         o_op1 <= w_op1;                 o_op2 <= w_op2;
      o_operation <= w_operation; o_arith_logic <= w_arith_logic; o_rd <= w_rd;
      o_rd_we <= w_rd_we;      o_is_load <= w_is_load;         o_is_store <= w_is_store;
      o_is_branch <= w_is_branch; o_is_jump <= w_is_jump;      o_funct3_raw <= w_funct3;
      o_store_data <= i_rs2_data; o_imm <= w_imm;              o_pc <= i_pc;
      o_illegal <= w_illegal;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready, i_wb_valid;
  logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
  logic [4:0]  i_wb_rd;
  logic        o_ready, o_valid, o_arith_logic, o_rd_we;
  logic        o_is_load, o_is_store, o_is_branch, o_is_jump, o_illegal;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd;
  logic [2:0]  o_operation, o_funct3_raw;
  logic [31:0] o_op1, o_op2, o_store_data, o_imm, o_pc;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_op1(o_op1), .o_op2(o_op2),
    .o_operation(o_operation), .o_arith_logic(o_arith_logic), .o_rd(o_rd),
    .o_rd_we(o_rd_we), .o_is_load(o_is_load), .o_is_store(o_is_store),
    .o_is_branch(o_is_branch), .o_is_jump(o_is_jump), .o_funct3_raw(o_funct3_raw),
    .o_store_data(o_store_data), .o_imm(o_imm), .o_pc(o_pc), .o_illegal(o_illegal)
  );

  typedef struct {
    logic        valid;
    logic [31:0] op1, op2, imm, pc, sd;
    logic [2:0]  operation, f3;
    logic        al, rd_we, ld, st, br, jp, ill;
    logic [4:0]  rd;
  } exp_t;

  exp_t m;
  bit   busy [32];
  bit   last_ready;
  bit   after_reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural meaning of an instruction as seen by execute
  function automatic exp_t dec(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] ii, is, ib, iu, ij;
    bit we = 0;
    e = '{default: '0};
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu = {ins[31:12], 12'h000};
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.valid = 1; e.rd = ins[11:7]; e.f3 = ins[14:12]; e.sd = b; e.pc = pc;
    case (ins[6:0])
      7'h33: begin e.op1 = a; e.op2 = b; e.operation = ins[14:12]; e.al = ins[30]; we = 1; end
      7'h13: begin e.op1 = a; e.op2 = ii; e.imm = ii; e.operation = ins[14:12];
                   e.al = (ins[14:12] == 3'd5) ? ins[30] : 1'b0; we = 1; end
      7'h03: begin e.op1 = a; e.op2 = ii; e.imm = ii; e.ld = 1; we = 1; end
      7'h23: begin e.op1 = a; e.op2 = is; e.imm = is; e.st = 1; end
      7'h37: begin e.op2 = iu; e.imm = iu; we = 1; end
      7'h17: begin e.op1 = pc; e.op2 = iu; e.imm = iu; we = 1; end
      7'h6F: begin e.op1 = pc; e.op2 = 4; e.imm = ij; e.jp = 1; we = 1; end
      7'h67: begin e.op1 = pc; e.op2 = 4; e.imm = ii; e.jp = 1; we = 1; end
      7'h63: begin e.op1 = a; e.op2 = b; e.imm = ib; e.al = 1; e.br = 1; end
      default: e.ill = 1;
    endcase
    e.rd_we = we && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] opc);
    return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63};
  endfunction
  function automatic bit reads_rs2(input logic [6:0] opc);
    return opc inside {7'h33, 7'h23, 7'h63};
  endfunction
  function automatic bit still_busy(input logic [4:0] r);
    return busy[r] && !(i_wb_valid && i_wb_rd == r);
  endfunction

  // One clock: check combinational outputs, advance the model, check the bundle
  task automatic step();
    bit exp_ready, hz, acc;
    #1;
    hz = i_valid && ((reads_rs1(i_instr[6:0]) && still_busy(i_instr[19:15])) ||
                     (reads_rs2(i_instr[6:0]) && still_busy(i_instr[24:20])));
    exp_ready = !i_flush && !hz && (!m.valid || i_ready);
    if (!i_reset) begin
      chk("o_ready", 32'(o_ready), 32'(exp_ready));
      chk("o_rs1_addr", 32'(o_rs1_addr), 32'(i_instr[19:15]));
      chk("o_rs2_addr", 32'(o_rs2_addr), 32'(i_instr[24:20]));
    end
    last_ready = o_ready;
    acc = i_valid && exp_ready;
    after_reset = i_reset;
    if (i_reset) begin
      m = '{default: '0};
      foreach (busy[k]) busy[k] = 0;
    end else if (i_flush) begin
      m.valid = 0;
      foreach (busy[k]) busy[k] = 0;
    end else begin
      if (i_wb_valid) busy[i_wb_rd] = 0;
      if (acc) begin
        m = dec(i_instr, i_pc, i_rs1_data, i_rs2_data);
        if (m.rd_we) busy[m.rd] = 1;
      end else if (i_ready) m.valid = 0;
      busy[0] = 0;
    end
    @(posedge clk);
    #1;
    chk("o_valid", 32'(o_valid), 32'(m.valid));
    if (m.valid || after_reset) begin
      chk("o_op1", o_op1, m.op1);
      chk("o_op2", o_op2, m.op2);
      chk("o_operation", 32'(o_operation), 32'(m.operation));
      chk("o_arith_logic", 32'(o_arith_logic), 32'(m.al));
      chk("o_rd", 32'(o_rd), 32'(m.rd));
      chk("o_rd_we", 32'(o_rd_we), 32'(m.rd_we));
      chk("o_class", 32'({o_is_load, o_is_store, o_is_branch, o_is_jump, o_illegal}),
          32'({m.ld, m.st, m.br, m.jp, m.ill}));
      chk("o_funct3_raw", 32'(o_funct3_raw), 32'(m.f3));
      chk("o_store_data", o_store_data, m.sd);
      chk("o_imm", o_imm, m.imm);
      chk("o_pc", o_pc, m.pc);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy,
                       input logic wbv, input logic [4:0] wbr, input logic fl,
                       input logic [31:0] d1, input logic [31:0] d2);
    i_valid = v; i_instr = ins; i_ready = rdy; i_wb_valid = wbv; i_wb_rd = wbr;
    i_flush = fl; i_rs1_data = d1; i_rs2_data = d2; i_pc = 32'h0000_1000;
  endtask

  logic [6:0] opc_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37,
                               7'h17, 7'h6F, 7'h67, 7'h63, 7'h7F};

  initial begin
    logic [31:0] ins;
    i_reset = 1;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("reset o_valid", 32'(o_valid), 0);
    chk("reset o_op2", o_op2, 0);
    i_reset = 0;

    drive(1, 32'h0050_0093, 1, 0, 0, 0, 0, 0);               // ADDI x1,x0,5
    step();
    chk("addi valid", 32'(o_valid), 1);
    chk("addi op1", o_op1, 0);
    chk("addi op2", o_op2, 5);
    chk("addi rd/we", 32'({o_rd, o_rd_we, o_arith_logic, o_operation}), 32'({5'd1, 1'b1, 1'b0, 3'd0}));

    drive(1, 32'h4020_81B3, 1, 1, 5'd1, 0, 10, 3);            // SUB x3,x1,x2 with x1 retiring
    step();
    chk("sub op1", o_op1, 10);
    chk("sub op2", o_op2, 3);
    chk("sub al/op", 32'({o_arith_logic, o_operation}), 32'({1'b1, 3'd0}));

    drive(1, 32'h4020_D213, 1, 0, 0, 0, 7, 0);                // SRAI x4,x1,2
    step();
    chk("srai shamt", 32'(o_op2[4:0]), 2);
    chk("srai al/op", 32'({o_arith_logic, o_operation}), 32'({1'b1, 3'd5}));

    drive(0, 0, 1, 0, 0, 1, 0, 0);
    step();
    chk("flush valid", 32'(o_valid), 0);

    drive(1, 32'h0050_0093, 1, 0, 0, 0, 0, 0);
    step();
    drive(1, 32'h0010_8133, 1, 0, 0, 0, 5, 5);                // ADD x2,x1,x1 stalls on x1
    step();
    chk("raw stall", 32'(last_ready), 0);
    step();
    chk("raw stall 2", 32'(last_ready), 0);
    i_wb_valid = 1; i_wb_rd = 5'd1;
    step();
    chk("wb bypass ready", 32'(last_ready), 1);
    chk("wb bypass rd", 32'(o_rd), 2);

    drive(1, 32'h0070_0293, 0, 0, 0, 0, 0, 0);                // ADDI x5 under backpressure
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold ready", 32'(last_ready), 0);
      chk("hold rd", 32'(o_rd), 2);
    end
    i_ready = 1;
    step();
    chk("release rd", 32'(o_rd), 5);

    drive(0, 0, 1, 0, 0, 1, 0, 0);
    step();
    drive(1, 32'h0010_0013, 1, 0, 0, 0, 0, 0);                // ADDI x0,x0,1
    step();
    chk("x0 rd_we", 32'(o_rd_we), 0);
    drive(1, 32'h0000_02B3, 1, 0, 0, 0, 0, 0);                // ADD x5,x0,x0
    step();
    chk("x0 no stall", 32'(last_ready), 1);

    drive(1, 32'h0010_0393, 1, 0, 0, 0, 0, 0);                // ADDI x7,x0,1
    step();
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    step();
    drive(1, 32'h0003_8433, 1, 0, 0, 0, 1, 0);                // ADD x8,x7,x0 after flush
    step();
    chk("post-flush ready", 32'(last_ready), 1);
    chk("post-flush rd", 32'(o_rd), 8);

    drive(1, 32'h0000_007F, 1, 0, 0, 0, 0, 0);
    step();
    chk("illegal", 32'({o_valid, o_illegal, o_rd_we}), 32'(3'b110));

    for (int n = 0; n < 4000; n++) begin
      ins = $urandom;
      ins[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      i_reset    = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 59) == 0, $urandom, $urandom);
      i_pc = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
